approx_add_pipe: RTL and testbench

APPROX_ADD_PIPE -- requirements
Module: approx_add_pipe

---
 rtl/approx_add_pipe_if.sv | 29 ++
 rtl/approx_add_pipe.sv | 193 +++++++++++++++++++
 tb/tb_approx_add_pipe.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/approx_add_pipe_if.sv
// Handshake and data bundle of the approximate-adder pipeline.
// The master side produces operands and consumes results; the slave side is the adder.
interface approx_add_pipe_if #(
  parameter int WIDTH   = 8,
  parameter int APX_MAX = 4
);
  localparam int KW = $clog2(APX_MAX + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       mode;
  logic [KW-1:0]    apx_bits;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   err;

  modport master (
    output in_valid, a, b, mode, apx_bits, out_ready,
    input  in_ready, out_valid, sum, err
  );

  modport slave (
    input  in_valid, a, b, mode, apx_bits, out_ready,
    output in_ready, out_valid, sum, err
  );
endinterface

// File: rtl/approx_add_pipe.sv
// Two-stage approximate adder (exact / lower-OR / truncate / copy-B low part)
// with error reporting and saturating delivery statistics.
module approx_add_pipe #(
  parameter int WIDTH   = 8,
  parameter int APX_MAX = 4,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  approx_add_pipe_if.slave     io,
  input  logic                 stat_clr,
  output logic [WIDTH:0]       err_max,
  output logic [CNT_W-1:0]     res_cnt,
  output logic [CNT_W-1:0]     err_cnt
);
  localparam int            KW    = $clog2(APX_MAX + 1);
  localparam logic [KW-1:0] K_MAX = KW'(APX_MAX);

  logic             v1_q, v1_d, v2_q, v2_d;
  logic [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d, lo1_q, lo1_d;
  logic             cin1_q, cin1_d;
  logic [KW-1:0]    k1_q, k1_d;
  logic [WIDTH:0]   sum_q, sum_d, err_q, err_d, err_max_q, err_max_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d, err_cnt_q, err_cnt_d;

  logic             en1_s, en2_s, in_fire_s, out_fire_s;
  logic [KW-1:0]    k_s;
  logic [WIDTH-1:0] lo_mask_s, top_mask_s, lo_s;
  logic             cin_s;
  logic [WIDTH:0]   hi_s, approx_s, exact_s, diff_s;

  // Stage 2 frees when empty or draining; stage 1 frees when it can move forward.
  always_comb begin
    out_fire_s = v2_q & io.out_ready;
    en2_s      = ~v2_q | io.out_ready;
    en1_s      = ~v1_q | en2_s;
    in_fire_s  = io.in_valid & en1_s;
  end

  assign io.in_ready  = en1_s;
  assign io.out_valid = v2_q;
  assign io.sum       = sum_q;
  assign io.err       = err_q;
  assign err_max      = err_max_q;
  assign res_cnt      = res_cnt_q;
  assign err_cnt      = err_cnt_q;

  // Stage 1 combinational: effective k, low-part result and carry into the high part.
  always_comb begin
    if (io.mode == 2'b00) begin
      k_s = {KW{1'b0}};
    end else if (io.apx_bits > K_MAX) begin
      k_s = K_MAX;
    end else begin
      k_s = io.apx_bits;
    end
    for (int i = 0; i < WIDTH; i++) begin
      lo_mask_s[i]  = (i < int'(k_s));
      top_mask_s[i] = (i == int'(k_s) - 1);
    end
    case (io.mode)
      2'b01: begin
        lo_s  = (io.a | io.b) & lo_mask_s;
        cin_s = |(io.a & io.b & top_mask_s);
      end
      2'b10: begin
        lo_s  = {WIDTH{1'b0}};
        cin_s = 1'b0;
      end
      2'b11: begin
        lo_s  = io.b & lo_mask_s;
        cin_s = 1'b0;
      end
      default: begin
        lo_s  = {WIDTH{1'b0}};
        cin_s = 1'b0;
      end
    endcase
  end

  // Stage 1 next state: load on accept, otherwise hold or empty as stage 2 drains.
  always_comb begin
    if (in_fire_s) begin
      a1_d   = io.a;
      b1_d   = io.b;
      lo1_d  = lo_s;
      cin1_d = cin_s;
      k1_d   = k_s;
    end else begin
      a1_d   = a1_q;
      b1_d   = b1_q;
      lo1_d  = lo1_q;
      cin1_d = cin1_q;
      k1_d   = k1_q;
    end
    if (en1_s) begin
      v1_d = in_fire_s;
    end else begin
      v1_d = v1_q;
    end
  end

  // Stage 2 combinational: high-part add above bit k, exact reference and distance.
  always_comb begin
    hi_s     = {1'b0, a1_q >> k1_q} + {1'b0, b1_q >> k1_q} + {{WIDTH{1'b0}}, cin1_q};
    approx_s = (hi_s << k1_q) | {1'b0, lo1_q};
    exact_s  = {1'b0, a1_q} + {1'b0, b1_q};
    if (exact_s >= approx_s) begin
      diff_s = exact_s - approx_s;
    end else begin
      diff_s = approx_s - exact_s;
    end
  end

  // Stage 2 next state: results stay frozen while the consumer stalls.
  always_comb begin
    if (en2_s) begin
      v2_d = v1_q;
    end else begin
      v2_d = v2_q;
    end
    if (en2_s && v1_q) begin
      sum_d = approx_s;
      err_d = diff_s;
    end else begin
      sum_d = sum_q;
      err_d = err_q;
    end
  end

  // Statistics: clear beats a coincident delivery; counters stick at all-ones.
  always_comb begin
    res_cnt_d = res_cnt_q;
    err_cnt_d = err_cnt_q;
    err_max_d = err_max_q;
    if (stat_clr) begin
      res_cnt_d = {CNT_W{1'b0}};
      err_cnt_d = {CNT_W{1'b0}};
      err_max_d = {(WIDTH+1){1'b0}};
    end else if (out_fire_s) begin
      if (res_cnt_q != {CNT_W{1'b1}}) begin
        res_cnt_d = res_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        res_cnt_d = res_cnt_q;
      end
      if ((err_q != {(WIDTH+1){1'b0}}) && (err_cnt_q != {CNT_W{1'b1}})) begin
        err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        err_cnt_d = err_cnt_q;
      end
      if (err_q > err_max_q) begin
        err_max_d = err_q;
      end else begin
        err_max_d = err_max_q;
      end
    end else begin
      res_cnt_d = res_cnt_q;
      err_cnt_d = err_cnt_q;
      err_max_d = err_max_q;
    end
  end

  // State registers; reset empties the pipe and zeroes results and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      a1_q      <= {WIDTH{1'b0}};
      b1_q      <= {WIDTH{1'b0}};
      lo1_q     <= {WIDTH{1'b0}};
      cin1_q    <= 1'b0;
      k1_q      <= {KW{1'b0}};
      sum_q     <= {(WIDTH+1){1'b0}};
      err_q     <= {(WIDTH+1){1'b0}};
      err_max_q <= {(WIDTH+1){1'b0}};
      res_cnt_q <= {CNT_W{1'b0}};
      err_cnt_q <= {CNT_W{1'b0}};
    end else begin
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      a1_q      <= a1_d;
      b1_q      <= b1_d;
      lo1_q     <= lo1_d;
      cin1_q    <= cin1_d;
      k1_q      <= k1_d;
      sum_q     <= sum_d;
      err_q     <= err_d;
      err_max_q <= err_max_d;
      res_cnt_q <= res_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end
endmodule

// File: tb/tb_approx_add_pipe.sv
// Self-checking bench: directed vector table, backpressure/reset/clear sequences,
// and randomized traffic scored against an arithmetic reference model.
module tb_approx_add_pipe;
  localparam int W    = 8;
  localparam int AM   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          stat_clr;
  logic [W:0]    err_max;
  logic [CW-1:0] res_cnt;
  logic [CW-1:0] err_cnt;

  approx_add_pipe_if #(.WIDTH(W), .APX_MAX(AM)) bus ();

  approx_add_pipe #(.WIDTH(W), .APX_MAX(AM), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io       (bus.slave),
    .stat_clr (stat_clr),
    .err_max  (err_max),
    .res_cnt  (res_cnt),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int s; int e; } exp_t;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] mode;
    logic [2:0] apx;
    logic [8:0] s;
    logic [8:0] e;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  exp_t e_sb;
  int   m_res = 0, m_err = 0, m_max = 0, deliv = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: split at k, build the low part by the mode rule, add the high parts.
  function automatic int ref_sum(input int a, input int b, input int mode, input int apx);
    int k, p, lo, cin;
    k  = (apx > AM) ? AM : apx;
    p  = 1 << k;
    lo = 0;
    cin = 0;
    if (mode == 0 || k == 0) return a + b;
    case (mode)
      1: begin
        lo  = (a % p) | (b % p);
        cin = ((a % p) >= p / 2 && (b % p) >= p / 2) ? 1 : 0;
      end
      3: lo = b % p;
      default: lo = 0;
    endcase
    return (a / p + b / p + cin) * p + lo;
  endfunction

  function automatic int ref_err(input int a, input int b, input int s);
    return (a + b >= s) ? (a + b - s) : (s - a - b);
  endfunction

  // Scoreboard: inputs and outputs are stable here for the coming rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_res = 0; m_err = 0; m_max = 0; deliv = 0;
    end else begin
      chk("stat_res_cnt", 64'(res_cnt), 64'(m_res));
      chk("stat_err_cnt", 64'(err_cnt), 64'(m_err));
      chk("stat_err_max", 64'(err_max), 64'(m_max));
      if (bus.out_valid && bus.out_ready) begin
        chk("sb_pending", 64'(q.size() > 0), 64'(1));
        if (q.size() > 0) begin
          e_sb = q.pop_front();
          chk("sb_sum", 64'(bus.sum), 64'(e_sb.s));
          chk("sb_err", 64'(bus.err), 64'(e_sb.e));
          if (!stat_clr) begin
            deliv++;
            if (m_res < CMAX) m_res++;
            if (e_sb.e != 0 && m_err < CMAX) m_err++;
            if (e_sb.e > m_max) m_max = e_sb.e;
          end
        end
      end
      if (stat_clr) begin
        m_res = 0; m_err = 0; m_max = 0; deliv = 0;
      end
      if (bus.in_valid && bus.in_ready) begin
        e_sb.s = ref_sum(int'(bus.a), int'(bus.b), int'(bus.mode), int'(bus.apx_bits));
        e_sb.e = ref_err(int'(bus.a), int'(bus.b), e_sb.s);
        q.push_back(e_sb);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rand();
    bus.a        = 8'($urandom);
    bus.b        = 8'($urandom);
    bus.mode     = 2'($urandom);
    bus.apx_bits = 3'($urandom_range(0, 7));
  endtask

  function automatic int cur_sum();
    return ref_sum(int'(bus.a), int'(bus.b), int'(bus.mode), int'(bus.apx_bits));
  endfunction

  function automatic int cur_err();
    return ref_err(int'(bus.a), int'(bus.b), cur_sum());
  endfunction

  vec_t tv[8];
  int   rc, ec, s0, e0, s1, s2;
  logic acc;

  initial begin
    tv[0] = '{8'hFF, 8'h01, 2'b00, 3'd0, 9'h100, 9'h000};
    tv[1] = '{8'h0F, 8'h01, 2'b01, 3'd4, 9'h00F, 9'h001};
    tv[2] = '{8'hFF, 8'hFF, 2'b10, 3'd4, 9'h1E0, 9'h01E};
    tv[3] = '{8'h03, 8'h01, 2'b11, 3'd7, 9'h001, 9'h003};
    tv[4] = '{8'h03, 8'h03, 2'b01, 3'd2, 9'h007, 9'h001};
    tv[5] = '{8'h12, 8'h34, 2'b10, 3'd0, 9'h046, 9'h000};
    tv[6] = '{8'h0F, 8'hF0, 2'b11, 3'd3, 9'h0F8, 9'h007};
    tv[7] = '{8'h80, 8'h80, 2'b00, 3'd4, 9'h100, 9'h000};

    bus.in_valid = 1'b0; bus.a = 8'h00; bus.b = 8'h00; bus.mode = 2'b00;
    bus.apx_bits = 3'd0; bus.out_ready = 1'b1; stat_clr = 1'b0; acc = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_sum", 64'(bus.sum), 64'(0));
    chk("rst_err", 64'(bus.err), 64'(0));
    chk("rst_res_cnt", 64'(res_cnt), 64'(0));
    chk("rst_err_max", 64'(err_max), 64'(0));
    rst_n = 1'b1;
    #1 chk("rst_in_ready", 64'(bus.in_ready), 64'(1));

    // Directed vectors, one at a time through an empty pipe.
    for (int i = 0; i < 8; i++) begin
      bus.a = tv[i].a; bus.b = tv[i].b; bus.mode = tv[i].mode; bus.apx_bits = tv[i].apx;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk("vec_lat1_valid", 64'(bus.out_valid), 64'(0));
      tick();
      chk("vec_valid", 64'(bus.out_valid), 64'(1));
      chk("vec_sum", 64'(bus.sum), 64'(tv[i].s));
      chk("vec_err", 64'(bus.err), 64'(tv[i].e));
      rc = int'(res_cnt);
      ec = int'(err_cnt);
      tick();
      chk("vec_res_cnt", 64'(res_cnt), 64'(rc + 1));
      chk("vec_err_cnt", 64'(err_cnt), 64'(ec + ((tv[i].e != 9'h000) ? 1 : 0)));
      if (i == 2) chk("vec_err_max", 64'(err_max), 64'(9'h01E));
    end

    // Backpressure: two accepts fill the pipe, then the output must hold.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    set_rand(); s0 = cur_sum(); e0 = cur_err();
    #1 chk("bp_ready0", 64'(bus.in_ready), 64'(1));
    tick();
    set_rand(); s1 = cur_sum();
    #1 chk("bp_ready1", 64'(bus.in_ready), 64'(1));
    tick();
    set_rand(); s2 = cur_sum();
    #1 chk("bp_stall_ready", 64'(bus.in_ready), 64'(0));
    chk("bp_stall_valid", 64'(bus.out_valid), 64'(1));
    repeat (3) begin
      tick();
      chk("bp_hold_ready", 64'(bus.in_ready), 64'(0));
      chk("bp_hold_sum", 64'(bus.sum), 64'(s0));
      chk("bp_hold_err", 64'(bus.err), 64'(e0));
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_release_ready", 64'(bus.in_ready), 64'(1));
    tick();
    bus.in_valid = 1'b0;
    chk("bp_out1_valid", 64'(bus.out_valid), 64'(1));
    chk("bp_out1_sum", 64'(bus.sum), 64'(s1));
    tick();
    chk("bp_out2_valid", 64'(bus.out_valid), 64'(1));
    chk("bp_out2_sum", 64'(bus.sum), 64'(s2));
    tick();
    chk("bp_empty", 64'(bus.out_valid), 64'(0));

    // Random traffic; operands are held until accepted.
    for (int c = 0; c < 400; c++) begin
      if (!bus.in_valid || acc) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        set_rand();
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #2 acc = bus.in_valid && bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) tick();
    chk("drain_queue", 64'(q.size()), 64'(0));
    chk("drain_valid", 64'(bus.out_valid), 64'(0));
    chk("res_saturate", 64'(res_cnt), 64'((deliv >= CMAX) ? CMAX : deliv));

    // Reset with two transactions in flight.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    set_rand();
    tick();
    set_rand();
    tick();
    bus.in_valid = 1'b0;
    chk("rif_full_valid", 64'(bus.out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("rif_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rif_sum", 64'(bus.sum), 64'(0));
    chk("rif_res_cnt", 64'(res_cnt), 64'(0));
    chk("rif_err_cnt", 64'(err_cnt), 64'(0));
    chk("rif_err_max", 64'(err_max), 64'(0));
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1 chk("rif_in_ready", 64'(bus.in_ready), 64'(1));
    repeat (3) begin
      tick();
      chk("rif_no_output", 64'(bus.out_valid), 64'(0));
    end

    // Clear coincident with an output transfer.
    bus.in_valid = 1'b1;
    set_rand();
    tick();
    set_rand();
    tick();
    bus.in_valid = 1'b0;
    chk("clr_first_valid", 64'(bus.out_valid), 64'(1));
    tick();
    chk("clr_pre_res_cnt", 64'(res_cnt), 64'(1));
    chk("clr_second_valid", 64'(bus.out_valid), 64'(1));
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("clr_res_cnt", 64'(res_cnt), 64'(0));
    chk("clr_err_cnt", 64'(err_cnt), 64'(0));
    chk("clr_err_max", 64'(err_max), 64'(0));
    chk("clr_delivered", 64'(bus.out_valid), 64'(0));
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
